// File: rtl/sysctl_pkg.sv
// Shared constants for the system-control measurement peripheral.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sysctl_pkg;

   // Word offsets, i.e. reg_addr[5:2]
   localparam logic [3:0] OFF_ID           = 4'h0;
   localparam logic [3:0] OFF_CTRL         = 4'h1;
   localparam logic [3:0] OFF_CKIN_FREQ    = 4'h2;
   localparam logic [3:0] OFF_FLYBK_PERIOD = 4'h3;
   localparam logic [3:0] OFF_FRAME_COUNT  = 4'h4;
   localparam logic [3:0] OFF_SCRATCH      = 4'h5;

   // CTRL register bit positions
   localparam int CTRL_W          = 3;
   localparam int CTRL_LED_MANUAL = 0;
   localparam int CTRL_LED_VALUE  = 1;
   localparam int CTRL_TEST_CARD  = 2;

   localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA4C0_0001;

   // Width of the edge, result and period counters
   localparam int CNT_W = 24;

endpackage

// File: rtl/sysctl_freqmeter_edge_sync.sv
// Two-flop synchroniser with a history flop producing a one-cycle rising-edge pulse.
// Latency: the pulse is consumed by downstream logic on the 3rd clk edge after the input edge.
// Backpressure: none; every synchronised rising edge yields exactly one pulse.
module edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic hist;

   // Synchronise the async input and keep one cycle of history; reset clears all three
   // so an input held low through reset can never produce a pulse afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign pulse = sync2 & ~hist;

endmodule

// File: rtl/sysctl_freqmeter.sv
// Register-mapped clock frequency meter, flyback period/frame counter, LED and test-card control.
// Latency: writes land the cycle after reg_wstrobe; reg_rdata is combinational from reg_addr.
// Backpressure: none; every strobed write is accepted, reads are always available.
module sysctl_freqmeter
   import sysctl_pkg::*;
#(
   parameter int          CLK_RATE    = 62500000,
   parameter int          GATE_CYCLES = CLK_RATE / 1000,
   parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT,
   // Period counter width; the full 24 bits in silicon, narrower only to shorten timeout runs
   parameter int          PER_W       = CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   input  logic        reg_wstrobe,
   output logic [31:0] reg_rdata,
   input  logic        meas_clk_in,
   input  logic        flybk_in,
   output logic        led,
   output logic        test_card_en
);

   localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [PER_W-1:0]  PER_MAX   = '1;

   logic              meas_edge;
   logic              flybk_edge;
   logic [CTRL_W-1:0] ctrl;
   logic [31:0]       scratch;
   logic [GATE_W-1:0] gate_ctr;
   logic [CNT_W-1:0]  edge_ctr;
   logic [CNT_W-1:0]  edge_next;
   logic [CNT_W-1:0]  freq_result;
   logic              freq_valid;
   logic [PER_W-1:0]  per_ctr;
   logic [CNT_W-1:0]  per_ext;
   logic [CNT_W-1:0]  period_next;
   logic [CNT_W-1:0]  period;
   logic              flyb_valid;
   logic              timeout;
   logic              armed;
   logic [15:0]       frame_count;
   logic              wr_ctrl;
   logic              wr_scratch;
   logic              wr_restart;
   logic              unused_addr_bits;

   edge_sync u_meas_sync (
      .clk   (clk),
      .reset (reset),
      .din   (meas_clk_in),
      .pulse (meas_edge)
   );

   edge_sync u_flybk_sync (
      .clk   (clk),
      .reset (reset),
      .din   (flybk_in),
      .pulse (flybk_edge)
   );

   assign wr_ctrl          = reg_wstrobe && (reg_addr[5:2] == OFF_CTRL);
   assign wr_scratch       = reg_wstrobe && (reg_addr[5:2] == OFF_SCRATCH);
   assign wr_restart       = reg_wstrobe && (reg_addr[5:2] == OFF_CKIN_FREQ);
   assign unused_addr_bits = ^reg_addr[1:0];

   // Software-writable control and scratch registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl    <= '0;
         scratch <= '0;
      end else begin
         if (wr_ctrl)    ctrl    <= reg_wdata[CTRL_W-1:0];
         if (wr_scratch) scratch <= reg_wdata;
      end
   end

   // Edge count including this cycle's edge, saturating
   assign edge_next = (meas_edge && (edge_ctr != CNT_MAX)) ? edge_ctr + 1'b1 : edge_ctr;

   // Gated edge counter; a restart write beats the terminal cycle so nothing is latched then
   always_ff @(posedge clk) begin
      if (reset) begin
         gate_ctr    <= '0;
         edge_ctr    <= '0;
         freq_result <= '0;
         freq_valid  <= 1'b0;
      end else if (wr_restart) begin
         gate_ctr    <= '0;
         edge_ctr    <= '0;
         freq_valid  <= 1'b0;
      end else if (gate_ctr == GATE_LAST) begin
         gate_ctr    <= '0;
         edge_ctr    <= '0;
         freq_result <= edge_next;
         freq_valid  <= 1'b1;
      end else begin
         gate_ctr    <= gate_ctr + 1'b1;
         edge_ctr    <= edge_next;
      end
   end

   // per_ctr counts cycles since the last edge, so edges N cycles apart report N
   assign per_ext     = CNT_W'(per_ctr);
   assign period_next = (per_ext == CNT_MAX) ? per_ext : per_ext + 1'b1;

   // Flyback period: first edge only arms; a saturated counter means the signal died
   always_ff @(posedge clk) begin
      if (reset) begin
         per_ctr    <= '0;
         period     <= '0;
         flyb_valid <= 1'b0;
         timeout    <= 1'b0;
         armed      <= 1'b0;
      end else if (flybk_edge) begin
         per_ctr <= '0;
         armed   <= 1'b1;
         if (armed) begin
            period     <= period_next;
            flyb_valid <= 1'b1;
            timeout    <= 1'b0;
         end
      end else if (per_ctr == PER_MAX) begin
         timeout    <= 1'b1;
         flyb_valid <= 1'b0;
         armed      <= 1'b0;
      end else begin
         per_ctr <= per_ctr + 1'b1;
      end
   end

   // Frame counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count <= '0;
      end else if (flybk_edge) begin
         frame_count <= frame_count + 1'b1;
      end
   end

   // frame_count[5] gives a slow heartbeat when the LED is not under manual control
   assign led          = ctrl[CTRL_LED_MANUAL] ? ctrl[CTRL_LED_VALUE] : frame_count[5];
   assign test_card_en = ctrl[CTRL_TEST_CARD];

   // Combinational read mux; unmapped offsets read zero
   always_comb begin
      reg_rdata = '0;
      case (reg_addr[5:2])
         OFF_ID:           reg_rdata = ID_VALUE;
         OFF_CTRL:         reg_rdata = {{(32 - CTRL_W){1'b0}}, ctrl};
         OFF_CKIN_FREQ:    reg_rdata = {freq_valid, 7'b0, freq_result};
         OFF_FLYBK_PERIOD: reg_rdata = {flyb_valid, timeout, 6'b0, period};
         OFF_FRAME_COUNT:  reg_rdata = {16'b0, frame_count};
         OFF_SCRATCH:      reg_rdata = scratch;
         default:          reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_sysctl_freqmeter.sv
// Directed bench for sysctl_freqmeter with a short gate window and a narrow period counter.
// Latency: n/a.
// Backpressure: n/a.
module tb_sysctl_freqmeter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic        reg_wstrobe = 1'b0;
   logic [31:0] reg_rdata;
   logic        meas_clk_in = 1'b0;
   logic        flybk_in = 1'b0;
   logic        led;
   logic        test_card_en;
   logic        meas_en = 1'b0;
   logic [31:0] rd_val;

   int n_chk  = 0;
   int n_pass = 0;

   sysctl_freqmeter #(
      .CLK_RATE    (62500000),
      .GATE_CYCLES (100),
      .ID_VALUE    (32'hA4C0_0001),
      .PER_W       (12)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_wstrobe  (reg_wstrobe),
      .reg_rdata    (reg_rdata),
      .meas_clk_in  (meas_clk_in),
      .flybk_in     (flybk_in),
      .led          (led),
      .test_card_en (test_card_en)
   );

   // clk period 10; measured clock period 40 (clk/4), toggling on clk falling edges
   always #5 clk = ~clk;
   always #20 if (meas_en) meas_clk_in = ~meas_clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d);
      reg_addr = a;
      #1;
      d = reg_rdata;
   endtask

   task automatic rdchk(input string tag, input logic [5:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(tag, d, exp);
   endtask

   // Strobe is sampled on the next rising edge; returns on the falling edge after it
   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      reg_addr    = a;
      reg_wdata   = d;
      reg_wstrobe = 1'b1;
      @(negedge clk);
      reg_wstrobe = 1'b0;
   endtask

   // Raise flybk now, hold 3 cycles, return gap cycles after the rise
   task automatic flybk_pulse(input int gap);
      flybk_in = 1'b1;
      repeat (3) @(negedge clk);
      flybk_in = 1'b0;
      repeat (gap - 3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (4) @(negedge clk);
      reset = 1'b0;

      // Reset state
      rdchk("rst_id",    6'h00, 32'hA4C0_0001);
      rdchk("rst_ctrl",  6'h04, 32'h0);
      rdchk("rst_ckin",  6'h08, 32'h0);
      rdchk("rst_flybk", 6'h0C, 32'h0);
      rdchk("rst_frame", 6'h10, 32'h0);
      rdchk("rst_scr",   6'h14, 32'h0);
      rdchk("unmap_18",  6'h18, 32'h0);
      rdchk("unmap_3c",  6'h3C, 32'h0);
      chk("rst_led", {31'b0, led}, 32'h0);
      chk("rst_tce", {31'b0, test_card_en}, 32'h0);

      // RO registers ignore writes; CTRL keeps only its three bits
      @(negedge clk);
      wr(6'h00, 32'h1234_5678);
      rdchk("id_ro", 6'h00, 32'hA4C0_0001);
      wr(6'h10, 32'h0000_FFFF);
      rdchk("frame_ro", 6'h10, 32'h0);
      wr(6'h04, 32'hFFFF_FFF8);
      rdchk("ctrl_mask", 6'h04, 32'h0);

      // Frequency: clk/4 gives 25 edges per 100-cycle window
      meas_en = 1'b1;
      repeat (250) @(negedge clk);
      wr(6'h08, 32'h0);
      repeat (99) @(negedge clk);
      rdchk("freq_pending", 6'h08, 32'h0000_0019);
      @(negedge clk);
      rdchk("freq_valid", 6'h08, 32'h8000_0019);

      // Restart landing on the terminal cycle: nothing latched, result retained
      repeat (99) @(negedge clk);
      wr(6'h08, 32'h0);
      repeat (60) @(negedge clk);
      rdchk("restart_term", 6'h08, 32'h0000_0019);
      repeat (60) @(negedge clk);
      rdchk("after_restart", 6'h08, 32'h8000_0019);

      // Mid-measurement reset clears results
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      meas_en = 1'b0;
      rdchk("mid_rst_ckin", 6'h08, 32'h0);

      // Flyback period
      flybk_pulse(1000);
      rdchk("flyb_first", 6'h0C, 32'h0);
      rdchk("frame_1", 6'h10, 32'd1);
      flybk_pulse(3);
      rdchk("flyb_1000", 6'h0C, 32'h8000_03E8);
      rdchk("frame_2", 6'h10, 32'd2);

      // Timeout of the 12-bit counter lands exactly 4096 cycles after the last edge
      repeat (4095) @(negedge clk);
      rd(6'h0C, rd_val);
      chk("pre_timeout", {30'b0, rd_val[31:30]}, 32'h2);
      @(negedge clk);
      rd(6'h0C, rd_val);
      chk("timeout", {30'b0, rd_val[31:30]}, 32'h1);
      flybk_pulse(500);
      rd(6'h0C, rd_val);
      chk("rearm_only", {30'b0, rd_val[31:30]}, 32'h1);
      flybk_pulse(3);
      rdchk("flyb_500", 6'h0C, 32'h8000_01F4);
      rdchk("frame_4", 6'h10, 32'd4);

      // LED and test card
      wr(6'h04, 32'h3);
      chk("led_manual_on", {31'b0, led}, 32'h1);
      wr(6'h04, 32'h1);
      chk("led_manual_off", {31'b0, led}, 32'h0);
      wr(6'h04, 32'h4);
      chk("tce_on", {31'b0, test_card_en}, 32'h1);
      rdchk("ctrl_4", 6'h04, 32'h4);
      repeat (27) flybk_pulse(8);
      rdchk("frame_31", 6'h10, 32'd31);
      chk("led_f31", {31'b0, led}, 32'h0);
      flybk_pulse(8);
      rdchk("frame_32", 6'h10, 32'd32);
      chk("led_f32", {31'b0, led}, 32'h1);

      // Flyback edge and CTRL write in the same cycle both take effect
      flybk_in = 1'b1;
      repeat (2) @(negedge clk);
      wr(6'h04, 32'h3);
      flybk_in = 1'b0;
      repeat (3) @(negedge clk);
      rdchk("coinc_frame", 6'h10, 32'd33);
      rdchk("coinc_ctrl", 6'h04, 32'h3);
      chk("coinc_tce", {31'b0, test_card_en}, 32'h0);

      // Scratch
      wr(6'h14, 32'hDEAD_BEEF);
      rdchk("scratch_a", 6'h14, 32'hDEAD_BEEF);
      wr(6'h14, 32'h1234_5678);
      rdchk("scratch_b", 6'h14, 32'h1234_5678);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
